// File: rtl/dmem_sram_bridge.sv
// dmem_sram_bridge: M-stage data memory port onto an SRAM-like req/addr_ok/data_ok bus.
// One transaction in flight; a flushed access that was already accepted is drained and dropped.
module dmem_sram_bridge #(
  parameter int unsigned KSEG_MAP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mem_ren_i,
  input  logic [3:0]  mem_wen_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        stall_pipe_i,
  input  logic        flush_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_stall_o,
  output logic        data_req_o,
  output logic        data_wr_o,
  output logic [1:0]  data_size_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_addr_ok_i,
  input  logic        data_data_ok_i,
  input  logic [31:0] data_rdata_i
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    DRAIN
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        access;
  logic        issue;
  logic        capture;
  logic [3:0]  en;
  logic [1:0]  size;
  logic [31:0] addr_phys;

  assign access = (|mem_ren_i) | (|mem_wen_i);
  assign en     = (|mem_wen_i) ? mem_wen_i : mem_ren_i;

  always_comb begin
    size = 2'd2;
    case (en)
      4'b1111:                            size = 2'd2;
      4'b0011, 4'b1100:                   size = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 2'd0;
      default:                            size = 2'd2;
    endcase
  end

  // kseg0/kseg1 fold onto the low 512 MB of physical space
  assign addr_phys = (KSEG_MAP != 0) ? {3'b000, mem_addr_i[28:0]}
                                     : mem_addr_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (access && !flush_i) begin
          state_nx = REQ;
          issue    = 1'b1;
        end
      end
      REQ: begin
        if (data_addr_ok_i) begin
          state_nx = flush_i ? DRAIN : WAIT;
        end else if (flush_i) begin
          state_nx = IDLE;
        end
      end
      WAIT: begin
        if (data_data_ok_i) begin
          if (flush_i) begin
            state_nx = IDLE;
          end else begin
            state_nx = DONE;
            capture  = !data_wr_o;
          end
        end else if (flush_i) begin
          state_nx = DRAIN;
        end
      end
      DONE: begin
        if (!stall_pipe_i || flush_i) begin
          state_nx = IDLE;
        end
      end
      DRAIN: begin
        if (data_data_ok_i) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_wr_o    <= 1'b0;
      data_size_o  <= 2'd0;
      data_addr_o  <= 32'd0;
      data_wdata_o <= 32'd0;
      mem_rdata_o  <= 32'd0;
    end else begin
      if (issue) begin
        data_wr_o    <= |mem_wen_i;
        data_size_o  <= size;
        data_addr_o  <= addr_phys;
        data_wdata_o <= mem_wdata_i;
      end
      if (capture) begin
        mem_rdata_o <= data_rdata_i;
      end
    end
  end

  assign data_req_o  = (state == REQ);
  assign mem_stall_o = access && (state != DONE);

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// tb_dmem_sram_bridge: directed scenarios plus randomized traffic against a
// transaction-level model of the bridge; second instance runs with KSEG_MAP=0.
module tb_dmem_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ren, wen;
  logic [31:0] addr, wdata, rdata;
  logic        stall_pipe, flush, aok, dok;

  logic [31:0] mem_rdata, data_addr, data_wdata;
  logic        mem_stall, data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] mem_rdata0, data_addr0, data_wdata0;
  logic        mem_stall0, data_req0, data_wr0;
  logic [1:0]  data_size0;

  // transaction-level model
  bit          asking, inflight, drop, hold;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_sram_bridge dut (
    .clk(clk), .rst(rst),
    .mem_ren_i(ren), .mem_wen_i(wen),
    .mem_addr_i(addr), .mem_wdata_i(wdata),
    .stall_pipe_i(stall_pipe), .flush_i(flush),
    .mem_rdata_o(mem_rdata), .mem_stall_o(mem_stall),
    .data_req_o(data_req), .data_wr_o(data_wr),
    .data_size_o(data_size), .data_addr_o(data_addr),
    .data_wdata_o(data_wdata),
    .data_addr_ok_i(aok), .data_data_ok_i(dok),
    .data_rdata_i(rdata)
  );

  dmem_sram_bridge #(.KSEG_MAP(0)) dut0 (
    .clk(clk), .rst(rst),
    .mem_ren_i(ren), .mem_wen_i(wen),
    .mem_addr_i(addr), .mem_wdata_i(wdata),
    .stall_pipe_i(stall_pipe), .flush_i(flush),
    .mem_rdata_o(mem_rdata0), .mem_stall_o(mem_stall0),
    .data_req_o(data_req0), .data_wr_o(data_wr0),
    .data_size_o(data_size0), .data_addr_o(data_addr0),
    .data_wdata_o(data_wdata0),
    .data_addr_ok_i(aok), .data_data_ok_i(dok),
    .data_rdata_i(rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] size_of(input logic [3:0] e);
    int n;
    n = $countones(e);
    if (n == 1) return 2'd0;
    if (n == 2 && (e[1:0] == 2'b11 || e[3:2] == 2'b11)) return 2'd1;
    return 2'd2;
  endfunction

  task automatic model_update();
    logic acc;
    acc = (|ren) | (|wen);
    if (rst) begin
      asking = 0; inflight = 0; drop = 0; hold = 0;
      m_wr = 0; m_size = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
    end else if (hold) begin
      if (!stall_pipe || flush) hold = 0;
    end else if (inflight) begin
      if (dok) begin
        inflight = 0;
        if (!drop && !flush) begin
          hold = 1;
          if (!m_wr) m_rdata = rdata;
        end
        drop = 0;
      end else if (flush) begin
        drop = 1;
      end
    end else if (asking) begin
      if (aok) begin
        asking = 0;
        inflight = 1;
        drop = flush;
      end else if (flush) begin
        asking = 0;
      end
    end else if (acc && !flush) begin
      asking  = 1;
      m_wr    = |wen;
      m_size  = size_of((|wen) ? wen : ren);
      m_addr  = addr;
      m_wdata = wdata;
    end
  endtask

  task automatic drv(input logic [3:0] r, input logic [3:0] w,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic sp, input logic fl,
                     input logic ao, input logic dk,
                     input logic [31:0] rd);
    ren = r; wen = w; addr = a; wdata = d;
    stall_pipe = sp; flush = fl; aok = ao; dok = dk; rdata = rd;
  endtask

  // settle to the falling edge, then compare every output with the model
  task automatic settle();
    logic stall_exp;
    #4;
    stall_exp = ((|ren) | (|wen)) && !hold;
    chk("req", data_req, asking);
    chk("wr", data_wr, m_wr);
    chk("size", data_size, m_size);
    chk("addr", data_addr, m_addr & 32'h1FFF_FFFF);
    chk("wdata", data_wdata, m_wdata);
    chk("rdata", mem_rdata, m_rdata);
    chk("stall", mem_stall, stall_exp);
    chk("req_k0", data_req0, asking);
    chk("addr_k0", data_addr0, m_addr);
    chk("rdata_k0", mem_rdata0, m_rdata);
    chk("stall_k0", mem_stall0, stall_exp);
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drv(4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    adv();
    // reset with an access present: stall follows access
    drv(4'hF, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("rst_stall", mem_stall, 1'b1);
    adv();
    rst = 1'b0;
    drv(4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("rst_req", data_req, 1'b0);
    chk("rst_wr", data_wr, 1'b0);
    chk("rst_size", data_size, 2'd0);
    chk("rst_addr", data_addr, 32'h0);
    chk("rst_wdata", data_wdata, 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_stall0", mem_stall, 1'b0);
    adv();

    // load word, minimum latency
    drv(4'hF, 4'h0, 32'h8000_0010, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("lw_c0_stall", mem_stall, 1'b1);
    chk("lw_c0_req", data_req, 1'b0);
    adv();
    drv(4'hF, 4'h0, 32'h8000_0010, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    settle();
    chk("lw_c1_req", data_req, 1'b1);
    chk("lw_c1_addr", data_addr, 32'h0000_0010);
    chk("lw_c1_addr_k0", data_addr0, 32'h8000_0010);
    chk("lw_c1_size", data_size, 2'd2);
    chk("lw_c1_wr", data_wr, 1'b0);
    chk("lw_c1_stall", mem_stall, 1'b1);
    adv();
    drv(4'hF, 4'h0, 32'h8000_0010, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    settle();
    chk("lw_c2_req", data_req, 1'b0);
    chk("lw_c2_stall", mem_stall, 1'b1);
    adv();
    drv(4'hF, 4'h0, 32'h8000_0010, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("lw_c3_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("lw_c3_stall", mem_stall, 1'b0);
    adv();
    drv(4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    adv();

    // store byte, addr_ok three cycles late; inputs change while held
    drv(4'h0, 4'b0100, 32'hA000_0003, 32'h00AB_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("sb_c0_stall", mem_stall, 1'b1);
    adv();
    for (int k = 0; k < 4; k++) begin
      drv(4'h0, 4'b0100, 32'h1234_5678, 32'h5A5A_5A5A, 1'b0, 1'b0,
          (k == 3), 1'b0, 32'h0);
      settle();
      chk("sb_req", data_req, 1'b1);
      chk("sb_size", data_size, 2'd0);
      chk("sb_wr", data_wr, 1'b1);
      chk("sb_addr", data_addr, 32'h0000_0003);
      chk("sb_wdata", data_wdata, 32'h00AB_0000);
      adv();
    end
    drv(4'h0, 4'b0100, 32'hA000_0003, 32'h00AB_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7777_7777);
    settle();
    chk("sb_wait_req", data_req, 1'b0);
    adv();
    drv(4'h0, 4'b0100, 32'hA000_0003, 32'h00AB_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("sb_done_stall", mem_stall, 1'b0);
    chk("sb_rdata_kept", mem_rdata, 32'hDEAD_BEEF);
    adv();
    drv(4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    adv();

    // flush in WAIT, response drained, next access waits
    drv(4'hF, 4'h0, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle(); adv();
    drv(4'hF, 4'h0, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    settle(); adv();
    drv(4'hF, 4'h0, 32'h0000_0100, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    settle(); adv();
    drv(4'b0011, 4'h0, 32'h0000_0200, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("fw_drain_stall", mem_stall, 1'b1);
    chk("fw_drain_req", data_req, 1'b0);
    adv();
    drv(4'b0011, 4'h0, 32'h0000_0200, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
    settle();
    chk("fw_dok_req", data_req, 1'b0);
    adv();
    drv(4'b0011, 4'h0, 32'h0000_0200, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("fw_after_req", data_req, 1'b0);
    chk("fw_rdata_kept", mem_rdata, 32'hDEAD_BEEF);
    adv();
    drv(4'b0011, 4'h0, 32'h0000_0200, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    settle();
    chk("fw_new_req", data_req, 1'b1);
    chk("fw_new_size", data_size, 2'd1);
    chk("fw_new_addr", data_addr, 32'h0000_0200);
    adv();
    drv(4'b0011, 4'h0, 32'h0000_0200, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_5555);
    settle(); adv();
    drv(4'b0011, 4'h0, 32'h0000_0200, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("fw_new_rdata", mem_rdata, 32'h0000_5555);
    adv();
    drv(4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle(); adv();

    // flush in REQ without addr_ok
    drv(4'b0001, 4'h0, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle(); adv();
    drv(4'b0001, 4'h0, 32'h0000_0001, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    chk("fr_req", data_req, 1'b1);
    chk("fr_size", data_size, 2'd0);
    adv();
    drv(4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("fr_req_drop", data_req, 1'b0);
    adv();

    // DONE held by another stall source
    drv(4'hF, 4'h0, 32'h0000_0040, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle(); adv();
    drv(4'hF, 4'h0, 32'h0000_0040, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    settle(); adv();
    drv(4'hF, 4'h0, 32'h0000_0040, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
    settle(); adv();
    for (int k = 0; k < 3; k++) begin
      drv(4'hF, 4'h0, 32'h0000_0040, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      settle();
      chk("dh_stall", mem_stall, 1'b0);
      chk("dh_rdata", mem_rdata, 32'hCAFE_F00D);
      chk("dh_req", data_req, 1'b0);
      adv();
    end
    drv(4'hF, 4'h0, 32'h0000_0040, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("dh_release_stall", mem_stall, 1'b0);
    adv();
    drv(4'hF, 4'h0, 32'h0000_0044, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("dh_next_req0", data_req, 1'b0);
    chk("dh_next_stall", mem_stall, 1'b1);
    adv();
    drv(4'hF, 4'h0, 32'h0000_0044, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    settle();
    chk("dh_next_req1", data_req, 1'b1);
    chk("dh_next_addr", data_addr, 32'h0000_0044);
    adv();

    // reset in WAIT abandons the load
    drv(4'hF, 4'h0, 32'h0000_0044, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    settle(); adv();
    rst = 1'b0;
    drv(4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("mr_rdata", mem_rdata, 32'h0);
    chk("mr_req", data_req, 1'b0);
    chk("mr_addr", data_addr, 32'h0);
    adv();

    // randomized traffic, bus slave driven from the model
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(63) == 0);
      ren        = ($urandom_range(2) == 0) ? 4'b0 : 4'($urandom);
      wen        = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0;
      addr       = $urandom;
      wdata      = $urandom;
      rdata      = $urandom;
      stall_pipe = ($urandom_range(2) == 0);
      flush      = ($urandom_range(9) == 0);
      aok        = asking && ($urandom_range(2) == 0);
      if (inflight) dok = ($urandom_range(2) == 0);
      else dok = !hold && !aok && ($urandom_range(7) == 0);
      settle();
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
